// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and elaboration helpers for the sliced add/subtract pipeline.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Width of one ripple slice; guarded so a bad STAGES value reaches the
  // parameter check instead of dividing by zero.
  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? width / stages : 1;
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle between the ALU and the pipelined adder.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );

endinterface

// File: rtl/pipelined_adder_slice.sv
// Combinational W-bit ripple-carry slice built from 1-bit full-adder cells.
module pipelined_adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         c_msb_in
);

  logic [W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out    = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES ripple slices with a registered carry
// between slices; one op per cycle, in-order results after STAGES cycles.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic               clk,
  input logic               rst,
  pipelined_adder_if.slave  bus
);

  localparam int SW   = slice_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_r;

  // Subtraction is a + ~b + 1, so carry-in is forced high and c_in ignored.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.c_in;

  // Stall is global: every stage holds while the consumer refuses a result.
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = rst || !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * SW;

    logic [REM-1:0]        op_a;
    logic [REM-1:0]        op_b;
    logic                  op_c;
    logic                  op_v;
    logic [SW-1:0]         s;
    logic                  c_top;
    logic                  c_msb;
    logic [(k+1)*SW-1:0]   s_next;
    logic [(k+1)*SW-1:0]   s_r;
    logic                  c_r;
    logic                  v_r;

    pipelined_adder_slice #(.W(SW)) u_slice (
      .a        (op_a[SW-1:0]),
      .b        (op_b[SW-1:0]),
      .c_in     (op_c),
      .s        (s),
      .c_out    (c_top),
      .c_msb_in (c_msb)
    );

    if (k == 0) begin : g_head
      assign op_a   = bus.a;
      assign op_b   = b_eff;
      assign op_c   = cin_eff;
      assign op_v   = bus.in_valid;
      assign s_next = s;
    end else begin : g_body
      assign op_a   = g_stage[k-1].g_fwd.a_r;
      assign op_b   = g_stage[k-1].g_fwd.b_r;
      assign op_c   = g_stage[k-1].c_r;
      assign op_v   = g_stage[k-1].v_r;
      assign s_next = {s, g_stage[k-1].s_r};
    end

    // ---- stage k -> k+1 boundary: unconsumed operand bits ride along ----
    if (k < LAST) begin : g_fwd
      logic [REM-SW-1:0] a_r;
      logic [REM-SW-1:0] b_r;
      logic              msb_unused;

      // Only the final slice's MSB carry feeds the overflow flag.
      assign msb_unused = c_msb;

      always_ff @(posedge clk) begin
        if (!stall) begin
          a_r <= op_a[REM-1:SW];
          b_r <= op_b[REM-1:SW];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
      end else if (!stall) begin
        v_r <= op_v;
      end
    end

    // Finished low sum bits are skewed along with the op; the last stage's
    // copy is the visible result, so it alone is cleared on reset.
    always_ff @(posedge clk) begin
      if (rst && (k == LAST)) begin
        s_r <= '0;
        c_r <= 1'b0;
      end else if (!stall) begin
        s_r <= s_next;
        c_r <= c_top;
      end
    end
  end

  // ---- final stage: overflow from the carries around the MSB ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (!stall) begin
      ovf_r <= g_stage[LAST].c_msb ^ g_stage[LAST].c_top;
    end
  end

  assign bus.out_valid = g_stage[LAST].v_r;
  assign bus.sum       = g_stage[LAST].s_r;
  assign bus.c_out     = g_stage[LAST].c_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder for STAGES = 4, 1 and 16 builds.
module tb_pipelined_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         c_in;
  logic         sub;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus4 ();
  pipelined_adder_if #(.WIDTH(W)) bus1 ();
  pipelined_adder_if #(.WIDTH(W)) bus16 ();

  assign bus4.in_valid  = in_valid;  assign bus4.a  = a;  assign bus4.b  = b;
  assign bus4.c_in      = c_in;      assign bus4.sub  = sub;  assign bus4.out_ready  = out_ready;
  assign bus1.in_valid  = in_valid;  assign bus1.a  = a;  assign bus1.b  = b;
  assign bus1.c_in      = c_in;      assign bus1.sub  = sub;  assign bus1.out_ready  = out_ready;
  assign bus16.in_valid = in_valid;  assign bus16.a = a;  assign bus16.b = b;
  assign bus16.c_in     = c_in;      assign bus16.sub = sub;  assign bus16.out_ready = out_ready;

  pipelined_adder #(.WIDTH(W), .STAGES(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  pipelined_adder #(.WIDTH(W), .STAGES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
  pipelined_adder #(.WIDTH(W), .STAGES(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  // Index 0: STAGES=4, 1: STAGES=1, 2: STAGES=16. Result packed as {ovf, c_out, sum}.
  logic        o_vld [3];
  logic        o_rdy [3];
  logic [17:0] o_res [3];

  assign o_vld[0] = bus4.out_valid;  assign o_rdy[0] = bus4.in_ready;
  assign o_vld[1] = bus1.out_valid;  assign o_rdy[1] = bus1.in_ready;
  assign o_vld[2] = bus16.out_valid; assign o_rdy[2] = bus16.in_ready;
  assign o_res[0] = {bus4.ovf, bus4.c_out, bus4.sum};
  assign o_res[1] = {bus1.ovf, bus1.c_out, bus1.sum};
  assign o_res[2] = {bus16.ovf, bus16.c_out, bus16.sum};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    int ux, uy, sx, sy, ur, sr;
    logic co, ov;
    logic [15:0] res;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end else begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      co = (ur > 65535);
    end
    ov  = (sr > 32767) || (sr < -32768);
    res = ur[15:0];
    return {ov, co, res};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: one queue of expected results per build.
  logic [17:0] q [3][$];
  int          n_acc [3] = '{0, 0, 0};
  logic        was_stall [3] = '{1'b0, 1'b0, 1'b0};
  logic [18:0] last_out [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        q[d].delete();
        check("rst_in_ready", 32'(o_rdy[d]), 32'd1);
      end else begin
        check("in_ready", 32'(o_rdy[d]), 32'(!(o_vld[d] && !out_ready)));
        if (was_stall[d]) check("stall_hold", 32'({o_vld[d], o_res[d]}), 32'(last_out[d]));
        if (o_vld[d] && out_ready) begin
          check("no_stale", 32'(q[d].size() != 0), 32'd1);
          if (q[d].size() != 0) check("result", 32'(o_res[d]), 32'(q[d].pop_front()));
        end
        if (in_valid && o_rdy[d]) begin
          q[d].push_back(model(a, b, c_in, sub));
          n_acc[d] <= n_acc[d] + 1;
        end
      end
      was_stall[d] <= !rst && o_vld[d] && !out_ready;
      last_out[d]  <= {o_vld[d], o_res[d]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ta [8];
  logic [15:0] tb_op [8];
  logic        tc [8];
  logic        ts [8];
  logic [17:0] te [8];

  task automatic gen_ops();
    for (int i = 0; i < 8; i++) begin
      ta[i]    = pick();
      tb_op[i] = pick();
      tc[i]    = 1'($urandom);
      ts[i]    = 1'($urandom);
      te[i]    = model(ta[i], tb_op[i], tc[i], ts[i]);
    end
  endtask

  task automatic drive_op(input int i);
    in_valid = 1'b1;
    a        = ta[i];
    b        = tb_op[i];
    c_in     = tc[i];
    sub      = ts[i];
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("reset_out_valid", 32'(bus4.out_valid), 32'd0);
    check("reset_outputs",   32'(o_res[0]), 32'd0);
    check("reset_in_ready",  32'(bus4.in_ready), 32'd1);
    rst = 1'b0;

    // 0xFFFF + 0x0001 wraps to zero with carry out
    a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t1_not_early", 32'(bus4.out_valid), 32'd0);
    tick();
    check("t1_valid",  32'(bus4.out_valid), 32'd1);
    check("t1_result", 32'(o_res[0]), 32'h10000);

    // Two subtractions back to back
    a = 16'h8000; b = 16'h0001; sub = 1'b1; c_in = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'h0003; b = 16'h0005; c_in = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t2_sub_ovf",    32'(o_res[0]), 32'h37FFF);
    tick();
    check("t2_sub_borrow", 32'(o_res[0]), 32'h0FFFE);
    check("t2_valid",      32'(bus4.out_valid), 32'd1);
    tick();

    // Eight back-to-back ops; results on consecutive cycles
    gen_ops();
    for (int t = 0; t < 11; t++) begin
      if (t < 8) drive_op(t);
      else in_valid = 1'b0;
      check("t3_in_ready", 32'(bus4.in_ready), 32'd1);
      tick();
      if (t >= 3) begin
        check("t3_valid",  32'(bus4.out_valid), 32'd1);
        check("t3_result", 32'(o_res[0]), 32'(te[t-3]));
      end
    end
    tick();
    check("t3_drained", 32'(bus4.out_valid), 32'd0);

    // Full pipe held by a 3-cycle consumer stall
    gen_ops();
    for (int t = 0; t < 4; t++) begin
      drive_op(t);
      tick();
    end
    out_ready = 1'b0;
    drive_op(4);
    #1;
    check("t4_in_ready_low", 32'(bus4.in_ready), 32'd0);
    check("t4_head",         32'(o_res[0]), 32'(te[0]));
    for (int t = 0; t < 3; t++) begin
      tick();
      check("t4_frozen",   32'(o_res[0]), 32'(te[0]));
      check("t4_held_vld", 32'(bus4.out_valid), 32'd1);
      check("t4_blocked",  32'(bus4.in_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      if (j < 4) drive_op(4 + j);
      else in_valid = 1'b0;
      tick();
      check("t4_resume", 32'(o_res[0]), 32'(te[j+1]));
    end
    tick();

    // Reset with three ops in flight and a simultaneous input
    gen_ops();
    for (int t = 0; t < 3; t++) begin
      drive_op(t);
      tick();
    end
    drive_op(3);
    rst = 1'b1;
    tick();
    check("t5_flush_vld", 32'(bus4.out_valid), 32'd0);
    check("t5_flush_res", 32'(o_res[0]), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      check("t5_no_stale", 32'(bus4.out_valid), 32'd0);
    end
    drive_op(4);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t5_not_early", 32'(bus4.out_valid), 32'd0);
    tick();
    check("t5_new_valid",  32'(bus4.out_valid), 32'd1);
    check("t5_new_result", 32'(o_res[0]), 32'(te[4]));
    tick();

    // Random traffic with random back-pressure on all builds
    cyc = 0;
    while ((n_acc[1] < 10000 || n_acc[2] < 10000) && cyc < 30000) begin
      in_valid  = ($urandom_range(0, 9) != 0);
      a         = pick();
      b         = pick();
      c_in      = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 7) != 0);
      tick();
      cyc++;
    end
    check("rand_budget", 32'(cyc < 30000), 32'd1);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (24) tick();
    for (int d = 0; d < 3; d++) check("drain_empty", 32'(q[d].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
